// File: rtl/safe_lock_pkg.sv
// Shared types and defaults for the safe lock keypad-side link.
package safe_lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    WAIT_RES = 3'd2,
    REPORT   = 3'd3,
    LOCKOUT  = 3'd4
  } tx_state_t;

  localparam int CODE_W       = 4;
  localparam int TIMEOUT_DEF  = 64;
  localparam int LOCKOUT_DEF  = 256;
  localparam int MAX_FAIL_DEF = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter shared by the verdict timeout and the lockout.
module safe_timer #(
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] cnt;

  // High on the cycle whose decrement brings the count to zero.
  assign zero = (cnt <= TW'(1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

endmodule

// File: rtl/code_entry_tx.sv
// Serialises a keypad code to the checker and tracks verdicts and lockout.
module code_entry_tx
  import safe_lock_pkg::*;
#(
  parameter int N           = CODE_W,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        code_val,
  input  logic [N-1:0]                code_data,
  output logic                        code_ready,
  output logic                        ser_val,
  output logic                        ser_data,
  input  logic                        ser_ready,
  input  logic                        result_val,
  input  logic                        result_data,
  output logic                        unlocked,
  output logic                        denied,
  output logic                        locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int TW = $clog2(max_int(TIMEOUT_CYC, LOCKOUT_CYC) + 1);
  localparam int CW = $clog2(N);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

  tx_state_t     state, state_n;
  logic [N-1:0]  shreg, shreg_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [FW-1:0] fail_n;
  logic          unl_n, den_n;
  logic          t_load, t_en, t_zero;
  logic [TW-1:0] t_val;

  safe_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = bit_cnt;
    fail_n  = fail_cnt;
    unl_n   = 1'b0;
    den_n   = 1'b0;
    t_load  = 1'b0;
    t_val   = TW'(TIMEOUT_CYC);
    t_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (code_val && code_ready) begin
          shreg_n = code_data;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready) begin
          shreg_n = {shreg[N-2:0], 1'b0};
          cnt_n   = bit_cnt + CW'(1);
          if (bit_cnt == LAST) begin
            if (result_val) begin
              state_n = REPORT;
              unl_n   = result_data;
              den_n   = !result_data;
            end else begin
              state_n = WAIT_RES;
              t_load  = 1'b1;
            end
          end
        end
      end
      WAIT_RES: begin
        t_en = 1'b1;
        if (result_val) begin
          state_n = REPORT;
          unl_n   = result_data;
          den_n   = !result_data;
        end else if (t_zero) begin
          state_n = REPORT;
          den_n   = 1'b1;
        end
      end
      REPORT: begin
        if (denied && fail_cnt == FMAX) begin
          state_n = LOCKOUT;
          t_load  = 1'b1;
          t_val   = TW'(LOCKOUT_CYC);
        end else begin
          state_n = IDLE;
        end
      end
      LOCKOUT: begin
        t_en = 1'b1;
        if (t_zero) begin
          state_n = IDLE;
          fail_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // The failure count moves together with the verdict pulse.
    if (unl_n) begin
      fail_n = '0;
    end else if (den_n && fail_cnt != FMAX) begin
      fail_n = fail_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      fail_cnt   <= '0;
      unlocked   <= 1'b0;
      denied     <= 1'b0;
      code_ready <= 1'b0;
      ser_val    <= 1'b0;
      ser_data   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= cnt_n;
      fail_cnt   <= fail_n;
      unlocked   <= unl_n;
      denied     <= den_n;
      code_ready <= (state_n == IDLE);
      ser_val    <= (state_n == SHIFT);
      ser_data   <= (state_n == SHIFT) && shreg_n[N-1];
      locked_out <= (state_n == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_code_entry_tx.sv
// Directed plus randomized transactions checked against a verdict-level model.
module tb_code_entry_tx;

  localparam int N  = 4;
  localparam int TO = 64;
  localparam int MF = 3;
  localparam int LO = 256;
  localparam int FW = $clog2(MF + 1);

  logic          clk, rstn;
  logic          code_val, code_ready;
  logic [N-1:0]  code_data;
  logic          ser_val, ser_data, ser_ready;
  logic          result_val, result_data;
  logic          unlocked, denied, locked_out;
  logic [FW-1:0] fail_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int fc          = 0;

  code_entry_tx #(
    .N(N), .TIMEOUT_CYC(TO), .MAX_FAIL(MF), .LOCKOUT_CYC(LO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .code_val    (code_val),
    .code_data   (code_data),
    .code_ready  (code_ready),
    .ser_val     (ser_val),
    .ser_data    (ser_data),
    .ser_ready   (ser_ready),
    .result_val  (result_val),
    .result_data (result_data),
    .unlocked    (unlocked),
    .denied      (denied),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (code_ready !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    chk("code_ready", 32'(code_ready), 1);
  endtask

  // rmode: 0 ready high, 1 fixed stall pattern, 2 random
  // vmode: 0 verdict d cycles into the wait, 1 with last bit, 2 none
  task automatic send(input logic [N-1:0] code, input int rmode,
                      input int vmode, input logic vdata, input int d);
    logic [6:0] pat;
    logic rdy, ok;
    int hs, cyc;
    pat = 7'b1001101;
    wait_ready();
    code_val  = 1'b1;
    code_data = code;
    tick();
    hs = 0;
    cyc = 0;
    while (hs < N && cyc < 200) begin
      chk("ser_val", 32'(ser_val), 1);
      chk("ser_data", 32'(ser_data), 32'(code[N-1-hs]));
      code_val = 1'b0;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc < 7) ? pat[6-cyc] : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ser_ready = rdy;
      if (rdy && hs == N - 1) begin
        result_val  = (vmode == 1);
        result_data = vdata;
      end else if (rmode == 2) begin
        result_val  = 1'($urandom_range(0, 1));
        result_data = 1'($urandom_range(0, 1));
        code_val    = 1'($urandom_range(0, 1));
        code_data   = N'($urandom);
      end else begin
        result_val = 1'b0;
      end
      tick();
      if (rdy) hs++;
      cyc++;
    end
    ser_ready  = 1'b0;
    result_val = 1'b0;
    code_val   = 1'b0;
    chk("handshakes", hs, N);
    if (vmode == 1) begin
      ok = vdata;
    end else begin
      chk("wait_ser_val", 32'(ser_val), 0);
      for (int k = 1; k <= TO; k++) begin
        chk("early_pulse", {30'd0, unlocked, denied}, 0);
        if (vmode == 0 && k == d) begin
          result_val  = 1'b1;
          result_data = vdata;
          tick();
          result_val = 1'b0;
          break;
        end
        tick();
      end
      ok = (vmode == 2) ? 1'b0 : vdata;
    end
    if (ok) fc = 0;
    else if (fc < MF) fc++;
    chk("unlocked", 32'(unlocked), 32'(ok));
    chk("denied", 32'(denied), 32'(!ok));
    chk("fail_cnt", 32'(fail_cnt), fc);
    tick();
    chk("pulse_end", {30'd0, unlocked, denied}, 0);
    if (fc == MF) begin
      for (int k = 0; k < LO; k++) begin
        chk("locked_out", 32'(locked_out), 1);
        chk("lock_ready", 32'(code_ready), 0);
        code_val  = 1'($urandom_range(0, 1));
        code_data = N'($urandom);
        tick();
      end
      code_val = 1'b0;
      fc = 0;
      chk("lock_end", 32'(locked_out), 0);
      chk("lock_fc", 32'(fail_cnt), fc);
      chk("lock_ready_after", 32'(code_ready), 1);
    end else begin
      chk("ready_after", 32'(code_ready), 1);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    code_val    = 1'b0;
    code_data   = '0;
    ser_ready   = 1'b0;
    result_val  = 1'b0;
    result_data = 1'b0;
    tick();
    tick();
    chk("rst_code_ready", 32'(code_ready), 0);
    chk("rst_ser_val", 32'(ser_val), 0);
    chk("rst_ser_data", 32'(ser_data), 0);
    chk("rst_pulses", {30'd0, unlocked, denied}, 0);
    chk("rst_locked", 32'(locked_out), 0);
    chk("rst_fail_cnt", 32'(fail_cnt), 0);
    rstn = 1'b1;

    send(4'b1011, 0, 0, 1'b1, 2);
    send(4'b1011, 1, 0, 1'b1, 1);
    send(4'b1001, 0, 1, 1'b0, 0);
    send(N'($urandom), 0, 2, 1'b1, 0);
    send(N'($urandom), 2, 0, 1'b0, 7);
    send(N'($urandom), 0, 0, 1'b1, TO);
    send(N'($urandom), 0, 0, 1'b0, 5);

    wait_ready();
    code_val  = 1'b1;
    code_data = 4'b1011;
    tick();
    code_val  = 1'b0;
    ser_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn      = 1'b1;
    ser_ready = 1'b0;
    fc = 0;
    chk("mid_rst_ser_val", 32'(ser_val), 0);
    chk("mid_rst_fail_cnt", 32'(fail_cnt), fc);
    chk("mid_rst_locked", 32'(locked_out), 0);
    tick();
    chk("mid_rst_idle", 32'(code_ready), 1);
    send(4'b1011, 0, 0, 1'b1, 3);

    for (int i = 0; i < 14; i++) begin
      send(N'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
           1'($urandom_range(0, 1)), $urandom_range(1, TO));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
